// File: rtl/mem_arbiter.sv
// Two-client memory arbiter: icache and dcache share one RAM port, with a starvation guard for icache.
// Define MEM_ARBITER_RR_EN for round-robin IDLE arbitration; otherwise dcache has fixed priority.
module mem_arbiter #(
  parameter int ISTARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  localparam logic [1:0] RAM_ACCESS = 2'b10;
  localparam int CW = ($clog2(ISTARVE_MAX + 1) > 3) ? $clog2(ISTARVE_MAX + 1) : 3;
  localparam logic [CW-1:0] STARVE_LIM = CW'(ISTARVE_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    IGNT = 2'b01,
    DGNT = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic          d_req;
  logic          access;

  assign d_req  = dREN | dWEN;
  assign access = (ramstate == RAM_ACCESS);
  assign iload  = ramload;
  assign dload  = ramload;

`ifdef MEM_ARBITER_RR_EN
  // High when dcache was the most recent owner; resets high so icache wins the first tie.
  logic last_d_q, last_d_d;

  always_comb begin
    last_d_d = last_d_q;
    if (state_d == IGNT && state_q != IGNT) last_d_d = 1'b0;
    if (state_d == DGNT && state_q != DGNT) last_d_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) last_d_q <= 1'b1;
    else     last_d_q <= last_d_d;
  end
`endif

  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (state_q)
      IDLE: begin
`ifdef MEM_ARBITER_RR_EN
        if (d_req && iREN) state_d = last_d_q ? IGNT : DGNT;
        else if (d_req)    state_d = DGNT;
        else if (iREN)     state_d = IGNT;
`else
        if (d_req)         state_d = DGNT;
        else if (iREN)     state_d = IGNT;
`endif
      end
      IGNT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (!iREN) begin
          state_d = IDLE;
        end else if (access) begin
          iwait   = 1'b0;
          state_d = IDLE;
        end
      end
      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (!d_req) begin
          state_d = IDLE;
        end else if (access) begin
          dwait = 1'b0;
          // Burst lock holds DGNT until icache has waited ISTARVE_MAX dcache words.
          if (iREN) begin
            if (dcnt_q + CW'(1) >= STARVE_LIM) begin
              state_d = IGNT;
              dcnt_d  = '0;
            end else begin
              dcnt_d = dcnt_q + CW'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) dcnt_d = '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ISTARVE_MAX, default 4; max consecutive dcache word transfers while iREN is pending before icache is forced a grant.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 iREN  input  1  icache read request.
REQ-005 iaddr  input  32  icache word address.
REQ-006 iload  output  32  icache read data.
REQ-007 iwait  output  1  icache stall; 0 for exactly the cycle its word completes.
REQ-008 dREN  input  1  dcache read request.
REQ-009 dWEN  input  1  dcache write request.
REQ-010 daddr  input  32  dcache word address.
REQ-011 dstore  input  32  dcache write data.
REQ-012 dload  output  32  dcache read data.
REQ-013 dwait  output  1  dcache stall; 0 for exactly the cycle its word completes.
REQ-014 ramREN  output  1  RAM read enable.
REQ-015 ramWEN  output  1  RAM write enable.
REQ-016 ramaddr  output  32  RAM address.
REQ-017 ramstore  output  32  RAM write data.
REQ-018 ramload  input  32  RAM read data.
REQ-019 ramstate  input  2  RAM status: FREE=00, BUSY=01, ACCESS=10, ERROR=11.

Function
REQ-020 FSM states SHALL be IDLE, IGNT, DGNT; one owner at a time; the RAM port SHALL never see both caches' requests in the same cycle.
REQ-021 IDLE: ram enables 0, iwait=dwait=1; next state DGNT if dREN|dWEN, else IGNT if iREN, else IDLE (dcache priority, 1-cycle arbitration latency).
REQ-022 DGNT: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&!dWEN (write wins if both asserted).
REQ-023 IGNT: ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
REQ-024 Owner's wait SHALL be 0 only when ramstate==ACCESS in its grant state; non-owner wait SHALL be 1.
REQ-025 iload=dload=ramload combinationally at all times.
REQ-026 On ACCESS in IGNT: next state IDLE.
REQ-027 On ACCESS in DGNT: 3-bit-or-wider counter dcnt increments when iREN=1; next state DGNT (burst lock) unless iREN=1 and dcnt+1==ISTARVE_MAX, then IGNT directly and dcnt cleared.
REQ-028 dcnt SHALL clear on any IGNT completion, and on entering IDLE; it SHALL saturate at ISTARVE_MAX.
REQ-029 FREE/BUSY/ERROR in a grant state: hold state and outputs; ERROR SHALL never deassert wait.
REQ-030 Owner drops its request before ACCESS: next state IDLE; ram enables 0 that same cycle (combinational from request).
REQ-031 Owner request low on ACCESS cycle is impossible per REQ-030; DGNT with dREN=dWEN=0 after lock SHALL go to IDLE.

Reset
REQ-032 RST=1 SHALL force IDLE, dcnt=0 immediately, regardless of clock.
REQ-033 Reset values: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
REQ-034 Reset mid-transfer SHALL abandon the access; no wait SHALL pulse low on the first post-reset cycle.

Configuration
REQ-035 Macro MEM_ARBITER_RR_EN defined: IDLE arbitration round-robin; on simultaneous requests, grant the cache not served last (last-served flag resets to dcache, so icache wins first tie).
REQ-036 MEM_ARBITER_RR_EN undefined: fixed dcache priority per REQ-021; starvation counter REQ-027 active in both builds.

Verification
REQ-037 iREN=1, iaddr=0x40, ramstate BUSY 2 cycles then ACCESS, ramload=0xDEADBEEF -> IGNT, ramREN=1, ramaddr=0x40, iwait=0 only on ACCESS cycle, iload=0xDEADBEEF.
REQ-038 dWEN=1 and iREN=1 same cycle, daddr=0x3100, dstore=0x5 -> DGNT first, ramWEN=1, ramstore=0x5; icache granted after dWEN drops.
REQ-039 dREN held across 6 one-cycle ACCESS words with iREN=1, ISTARVE_MAX=4 -> 4 dwait-low cycles, then IGNT, iwait low, then DGNT resumes.
REQ-040 ramstate=ERROR 5 cycles in DGNT -> dwait=1 throughout, outputs stable; ACCESS then completes normally.
REQ-041 RST asserted between clock edges while in DGNT with ramWEN=1 -> ramWEN=0, dwait=1 immediately; IDLE after release.
REQ-042 MEM_ARBITER_RR_EN defined, dREN and iREN both held from reset -> grant order IGNT, DGNT, IGNT, DGNT.
